// File: rtl/axi_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-lite master command port.
// Holds one command in flight, times it out if the master never completes, and returns data/err to the owner.
//   state     | meaning
//   IDLE      | sample requests, latch the winner's command
//   START     | one-cycle axi_wr/axi_rd pulse, timeout counter cleared
//   WAIT_BUSY | waiting for axi_busy to rise
//   WAIT_DONE | waiting for axi_busy to fall (completion)
//   RESP      | one-cycle ack to the owner, last-served updated
module axi_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic [31:0] axi_addr,
    output logic [31:0] axi_data_in,
    input  logic [31:0] axi_data_out,
    output logic        axi_wr,
    output logic        axi_rd,
    input  logic        axi_busy,
    input  logic        axi_err,
    output logic        grant,
    output logic        active
);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    localparam logic [15:0] CNT_LAST      = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        we, we_nxt;
    logic        last, last_nxt;
    logic [31:0] addr_nxt, data_nxt, r0_rdata_nxt, r1_rdata_nxt;
    logic        wr_nxt, rd_nxt, r0_ack_nxt, r1_ack_nxt, r0_err_nxt, r1_err_nxt;
    logic        grant_nxt, active_nxt;
    logic        win, timeout, go_resp, resp_err;
    logic [31:0] resp_rdata;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        we_nxt       = we;
        last_nxt     = last;
        addr_nxt     = axi_addr;
        data_nxt     = axi_data_in;
        grant_nxt    = grant;
        r0_rdata_nxt = r0_rdata;
        r1_rdata_nxt = r1_rdata;
        wr_nxt       = 1'b0;
        rd_nxt       = 1'b0;
        r0_ack_nxt   = 1'b0;
        r1_ack_nxt   = 1'b0;
        r0_err_nxt   = 1'b0;
        r1_err_nxt   = 1'b0;
        go_resp      = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = TIMEOUT_RDATA;
        win          = (r0_req && r1_req) ? ~last : r1_req;
        // The compare includes the current wait cycle, so the ack lands TIMEOUT_CYCLES after START.
        timeout      = ((cnt + 16'd1) == CNT_LAST);

        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    we_nxt    = win ? r1_we    : r0_we;
                    addr_nxt  = win ? r1_addr  : r0_addr;
                    data_nxt  = win ? r1_wdata : r0_wdata;
                    grant_nxt = win;
                    wr_nxt    = we_nxt;
                    rd_nxt    = ~we_nxt;
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                cnt_nxt = cnt + 16'd1;
                if (timeout) begin
                    go_resp  = 1'b1;
                    resp_err = 1'b1;
                end else if (axi_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_nxt = cnt + 16'd1;
                if (!axi_busy) begin
                    go_resp    = 1'b1;
                    resp_err   = axi_err;
                    resp_rdata = axi_data_out;
                end else if (timeout) begin
                    go_resp  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RESP: begin
                last_nxt  = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (go_resp) begin
            state_nxt = RESP;
            if (grant) begin
                r1_ack_nxt = 1'b1;
                r1_err_nxt = resp_err;
                if (!we) r1_rdata_nxt = resp_rdata;
            end else begin
                r0_ack_nxt = 1'b1;
                r0_err_nxt = resp_err;
                if (!we) r0_rdata_nxt = resp_rdata;
            end
        end

        active_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            we          <= 1'b0;
            last        <= 1'b1;
            axi_addr    <= '0;
            axi_data_in <= '0;
            axi_wr      <= 1'b0;
            axi_rd      <= 1'b0;
            grant       <= 1'b0;
            active      <= 1'b0;
            r0_ack      <= 1'b0;
            r0_err      <= 1'b0;
            r0_rdata    <= '0;
            r1_ack      <= 1'b0;
            r1_err      <= 1'b0;
            r1_rdata    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            we          <= we_nxt;
            last        <= last_nxt;
            axi_addr    <= addr_nxt;
            axi_data_in <= data_nxt;
            axi_wr      <= wr_nxt;
            axi_rd      <= rd_nxt;
            grant       <= grant_nxt;
            active      <= active_nxt;
            r0_ack      <= r0_ack_nxt;
            r0_err      <= r0_err_nxt;
            r0_rdata    <= r0_rdata_nxt;
            r1_ack      <= r1_ack_nxt;
            r1_err      <= r1_err_nxt;
            r1_rdata    <= r1_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Bench for axi_cmd_arbiter: transaction-level model of the arbiter plus a behavioural AXI master,
// compared against the DUT on every cycle; directed scenarios pin the model with literal values.
module tb_axi_cmd_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_d = '0, we_d = '0;
    logic [31:0] addr_d [2];
    logic [31:0] wdata_d [2];
    logic [31:0] dout_d = '0;
    logic        busy_d = 1'b0, aerr_d = 1'b0;

    logic        r0_ack, r0_err, r1_ack, r1_err, axi_wr, axi_rd, grant, active;
    logic [31:0] r0_rdata, r1_rdata, axi_addr, axi_data_in;

    axi_cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .r0_req(req_d[0]), .r0_we(we_d[0]), .r0_addr(addr_d[0]), .r0_wdata(wdata_d[0]),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(req_d[1]), .r1_we(we_d[1]), .r1_addr(addr_d[1]), .r1_wdata(wdata_d[1]),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .axi_addr(axi_addr), .axi_data_in(axi_data_in), .axi_data_out(dout_d),
        .axi_wr(axi_wr), .axi_rd(axi_rd), .axi_busy(busy_d), .axi_err(aerr_d),
        .grant(grant), .active(active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;

    // model: one command in flight, described by its accept cycle and predicted ack cycle
    bit          txn, m_owner, m_we, m_last, m_grant, m_ok, m_eresp, e_wr, e_rd, e_err, e_active;
    logic [1:0]  e_ack;
    int          c_acc, ack_cyc, blen;
    logic [31:0] m_rresp, m_axi_addr, m_axi_data;
    logic [31:0] m_rdata [2];

    // stimulus controls
    bit          mode_auto = 1'b0, use_dout = 1'b0;
    int          force_len = -1, force_err = -1;
    logic [31:0] dout_val = '0;
    int          hold_left [2];

    // DUT event monitor for the directed literal checks
    int          mon_pulses = 0, mon_pulse_cyc = 0, mon_ack_cyc = 0, mon_ack0 = 0, mon_ack1 = 0;
    logic [31:0] mon_paddr, mon_pdata;
    logic        mon_pwr, mon_err;
    int          ack_log [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        txn = 0; m_last = 1; m_grant = 0; m_axi_addr = '0; m_axi_data = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        e_wr = 0; e_rd = 0; e_ack = '0; e_err = 0; e_active = 0;
    endtask

    task automatic new_cmd(int i);
        we_d[i] = 1'($urandom_range(0, 1));
        addr_d[i] = $urandom;
        wdata_d[i] = $urandom;
    endtask

    task automatic issue(int i, bit we, logic [31:0] a, logic [31:0] d);
        req_d[i] = 1'b1; we_d[i] = we; addr_d[i] = a; wdata_d[i] = d;
    endtask

    task automatic step();
        int  n;
        bit  w, keep;
        @(posedge clk); #1;
        n = cyc;
        if (!txn) begin
            if (req_d != 2'b00) begin
                w = (req_d == 2'b11) ? ~m_last : req_d[1];
                txn = 1; c_acc = n - 1; m_owner = w; m_we = we_d[w]; m_grant = w;
                m_axi_addr = addr_d[w]; m_axi_data = wdata_d[w];
                blen = (force_len >= 0) ? force_len : int'($urandom_range(0, 7));
                m_ok = (blen != 0) && (2 + blen <= TO);
                ack_cyc = m_ok ? c_acc + 3 + blen : c_acc + TO + 1;
                m_eresp = 1; m_rresp = 32'hDEAD_BEEF;
            end
        end else if (n - 1 == ack_cyc) begin
            txn = 0;
        end
        // master: busy rises the cycle after the pulse and lasts blen cycles (0 = never)
        busy_d = txn && blen != 0 && n >= c_acc + 2 && n <= c_acc + 1 + blen;
        if (txn && (n == c_acc + 1 || n == ack_cyc) && $urandom_range(0, 3) == 0) busy_d = 1'b1;
        dout_d = use_dout ? dout_val : $urandom;
        aerr_d = (force_err >= 0) ? force_err[0] : ($urandom_range(0, 3) == 0);
        if (txn && m_ok && n == c_acc + 2 + blen) begin
            m_eresp = aerr_d;
            if (!m_we) m_rresp = dout_d;
        end
        e_active = txn;
        e_wr = txn && n == c_acc + 1 && m_we;
        e_rd = txn && n == c_acc + 1 && !m_we;
        e_ack = '0;
        if (txn && n == ack_cyc) begin
            e_ack[m_owner] = 1'b1;
            e_err = m_eresp;
            if (!m_we) m_rdata[m_owner] = m_rresp;
            m_last = m_owner;
        end
        for (int i = 0; i < 2; i++) begin
            if (e_ack[i]) begin
                if (mode_auto) keep = 1'($urandom_range(0, 1));
                else begin
                    if (hold_left[i] > 0) hold_left[i]--;
                    keep = hold_left[i] > 0;
                end
                req_d[i] = keep;
                if (keep && mode_auto) new_cmd(i);
            end else if (mode_auto && !req_d[i] && $urandom_range(0, 2) == 0) begin
                req_d[i] = 1'b1;
                new_cmd(i);
            end
        end
    endtask

    task automatic run_until_idle(int maxc);
        int k = 0;
        do begin
            step();
            k++;
        end while ((txn || req_d != 2'b00) && k < maxc);
        if (k >= maxc) begin
            n_cmp++; n_err++;
            $display("FAIL idle_wait cyc=%0d got=busy expected=idle within %0d cycles", cyc, maxc);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_axi_wr"}, axi_wr, 0);   chk({tag, "_axi_rd"}, axi_rd, 0);
        chk({tag, "_r0_ack"}, r0_ack, 0);   chk({tag, "_r1_ack"}, r1_ack, 0);
        chk({tag, "_r0_err"}, r0_err, 0);   chk({tag, "_r1_err"}, r1_err, 0);
        chk({tag, "_r0_rdata"}, r0_rdata, 0); chk({tag, "_r1_rdata"}, r1_rdata, 0);
        chk({tag, "_axi_addr"}, axi_addr, 0); chk({tag, "_axi_data_in"}, axi_data_in, 0);
        chk({tag, "_grant"}, grant, 0);     chk({tag, "_active"}, active, 0);
    endtask

    task automatic clear_force();
        force_len = -1; force_err = -1; use_dout = 1'b0;
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("axi_wr", axi_wr, e_wr);
        chk("axi_rd", axi_rd, e_rd);
        chk("r0_ack", r0_ack, e_ack[0]);
        chk("r1_ack", r1_ack, e_ack[1]);
        if (e_ack[0]) chk("r0_err", r0_err, e_err);
        if (e_ack[1]) chk("r1_err", r1_err, e_err);
        chk("r0_rdata", r0_rdata, m_rdata[0]);
        chk("r1_rdata", r1_rdata, m_rdata[1]);
        chk("axi_addr", axi_addr, m_axi_addr);
        chk("axi_data_in", axi_data_in, m_axi_data);
        chk("grant", grant, m_grant);
        chk("active", active, e_active);
    end

    always @(negedge clk) if (!reset) begin
        if (axi_wr || axi_rd) begin
            mon_pulses++; mon_pulse_cyc = cyc;
            mon_paddr = axi_addr; mon_pdata = axi_data_in; mon_pwr = axi_wr;
        end
        if (r0_ack) begin mon_ack0++; mon_ack_cyc = cyc; mon_err = r0_err; ack_log.push_back(0); end
        if (r1_ack) begin mon_ack1++; mon_ack_cyc = cyc; mon_err = r1_err; ack_log.push_back(1); end
    end

    initial begin
        int p0, a0, a1, bad, k;
        addr_d[0] = '0; addr_d[1] = '0; wdata_d[0] = '0; wdata_d[1] = '0;
        hold_left[0] = 0; hold_left[1] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("rst");
        reset = 1'b0;
        chk_en = 1'b1;

        // single write, busy for 3 cycles
        p0 = mon_pulses;
        force_len = 3; force_err = 0;
        issue(0, 1'b1, 32'h40, 32'h1234_5678);
        run_until_idle(50);
        chk("t_wr_pulses", mon_pulses - p0, 1);
        chk("t_wr_addr", mon_paddr, 32'h40);
        chk("t_wr_data", mon_pdata, 32'h1234_5678);
        chk("t_wr_dir", mon_pwr, 1);
        chk("t_wr_lat", mon_ack_cyc - mon_pulse_cyc, 5);
        chk("t_wr_err", mon_err, 0);

        // r1 read
        a0 = mon_ack0; a1 = mon_ack1;
        force_len = 2; force_err = 0; use_dout = 1'b1; dout_val = 32'hCAFE_0001;
        issue(1, 1'b0, 32'h80, 32'h0);
        run_until_idle(50);
        chk("t_rd1_rdata", r1_rdata, 32'hCAFE_0001);
        chk("t_rd1_r0ack", mon_ack0 - a0, 0);
        chk("t_rd1_r1ack", mon_ack1 - a1, 1);
        clear_force();

        // both hold requests for 4 commands each
        a0 = mon_ack0; a1 = mon_ack1;
        ack_log.delete();
        hold_left[0] = 4; hold_left[1] = 4;
        issue(0, 1'b1, 32'h1000, 32'hA);
        issue(1, 1'b0, 32'h2000, 32'h0);
        run_until_idle(200);
        bad = 0;
        for (int i = 1; i < ack_log.size(); i++) if (ack_log[i] == ack_log[i-1]) bad++;
        chk("t_rr_r0", mon_ack0 - a0, 4);
        chk("t_rr_r1", mon_ack1 - a1, 4);
        chk("t_rr_alt", bad, 0);
        chk("t_rr_first", ack_log.size() > 0 ? ack_log[0] : -1, 0);

        // minimum latency: busy for exactly one cycle
        force_len = 1; force_err = 0;
        issue(0, 1'b0, 32'h10, 32'h0);
        run_until_idle(50);
        chk("t_min_lat", mon_ack_cyc - mon_pulse_cyc, 3);

        // busy never rises: timeout
        force_len = 0;
        issue(0, 1'b0, 32'h200, 32'h0);
        run_until_idle(50);
        chk("t_to_lat", mon_ack_cyc - mon_pulse_cyc, 8);
        chk("t_to_err", mon_err, 1);
        chk("t_to_rdata", r0_rdata, 32'hDEAD_BEEF);

        // master error on a read
        force_len = 2; force_err = 1; use_dout = 1'b1; dout_val = 32'h5A5A_0041;
        issue(0, 1'b0, 32'h300, 32'h0);
        run_until_idle(50);
        chk("t_aerr_err", mon_err, 1);
        chk("t_aerr_rdata", r0_rdata, 32'h5A5A_0041);
        clear_force();

        // reset asserted in WAIT_DONE
        force_len = 5;
        issue(0, 1'b0, 32'h400, 32'h0);
        k = 0;
        do begin step(); k++; end while (!(txn && cyc == c_acc + 3) && k < 20);
        chk("t_rst_reached", k < 20, 1);
        chk_en = 1'b0;
        reset = 1'b1;
        #1 check_zero("mid_rst");
        model_reset();
        req_d = '0; busy_d = 1'b0;
        clear_force();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        a0 = mon_ack0; a1 = mon_ack1;
        issue(1, 1'b1, 32'h500, 32'h77);
        run_until_idle(50);
        chk("t_rst_r0ack", mon_ack0 - a0, 0);
        chk("t_rst_r1ack", mon_ack1 - a1, 1);

        // random traffic
        mode_auto = 1'b1;
        repeat (3000) step();
        mode_auto = 1'b0;
        hold_left[0] = 0; hold_left[1] = 0;
        run_until_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
